// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq: opcodes, flag bit positions, FSM states and
// the iterative-unit operation kinds.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  localparam int FL_C   = 0;
  localparam int FL_Z   = 1;
  localparam int FL_N   = 2;
  localparam int FL_V   = 3;
  localparam int FL_ILL = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IK_SHL = 2'd0,
    IK_SHR = 2'd1,
    IK_ASR = 2'd2,
    IK_MUL = 2'd3
  } iter_kind_t;

  function automatic logic [7:0] pack_flags(input logic c, input logic z, input logic n,
                                            input logic v, input logic ill);
    logic [7:0] f;
    f         = '0;
    f[FL_C]   = c;
    f[FL_Z]   = z;
    f[FL_N]   = n;
    f[FL_V]   = v;
    f[FL_ILL] = ill;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// One-bit-per-cycle shifter and shift-add multiplier with iteration counter.
// The multiplier registers exist only when ALU_MUL_EN is defined.
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             step_i,
  input  iter_kind_t       kind_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             last_o
);

  iter_kind_t       kind_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             c_d;
  logic [CNT_W-1:0] shift_cnt;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0]   sum;
`endif

  // Shift amounts of WIDTH or more saturate: further steps cannot change the result.
  assign shift_cnt = (b_i >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : b_i[CNT_W-1:0];

  always_comb begin
    acc_d = acc_q;
    c_d   = 1'b0;
`ifdef ALU_MUL_EN
    hi_d  = hi_q;
    sum   = '0;
`endif
    unique case (kind_q)
      IK_SHL: begin
        c_d   = acc_q[WIDTH-1];
        acc_d = {acc_q[WIDTH-2:0], 1'b0};
      end
      IK_SHR: begin
        c_d   = acc_q[0];
        acc_d = {1'b0, acc_q[WIDTH-1:1]};
      end
      IK_ASR: begin
        c_d   = acc_q[0];
        acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      end
      default: begin
`ifdef ALU_MUL_EN
        // acc_q holds the unconsumed multiplier bits, then the low product half.
        sum   = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        hi_d  = sum[WIDTH:1];
        acc_d = {sum[0], acc_q[WIDTH-1:1]};
        c_d   = |sum[WIDTH:1];
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q  <= IK_SHL;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef ALU_MUL_EN
      mcand_q <= '0;
      hi_q    <= '0;
`endif
    end else if (start_i) begin
      kind_q  <= kind_i;
      cnt_q   <= (kind_i == IK_MUL) ? CNT_W'(WIDTH) : shift_cnt;
`ifdef ALU_MUL_EN
      acc_q   <= (kind_i == IK_MUL) ? b_i : a_i;
      mcand_q <= a_i;
      hi_q    <= '0;
`else
      acc_q   <= a_i;
`endif
    end else if (step_i && (cnt_q != '0)) begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_q - 1'b1;
`ifdef ALU_MUL_EN
      hi_q    <= hi_d;
`endif
    end
  end

  // Next-state values are exported so the final step's result is captured on that same edge.
  assign res_o  = acc_d;
  assign c_o    = c_d;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic, iterative shifts and
// an optional shift-add multiply enabled by the ALU_MUL_EN macro.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [7:0]       fo
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [7:0]       fo_q, fo_d;

  logic [WIDTH:0]   sum;
  logic             cin;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill, is_iter;
  iter_kind_t       kind;

  logic             iter_start, iter_step, iter_c, iter_last;
  logic [WIDTH-1:0] iter_res;

  assign cin = ((op == OP_ADC) || (op == OP_SBB)) & ci;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    is_iter = 1'b0;
    kind    = IK_SHL;
    case (op)
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        // Bit WIDTH of the difference is the borrow.
        sum     = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL, OP_SHR, OP_ASR: begin
        alu_res = a;
        is_iter = (b != '0);
        kind    = (op == OP_SHL) ? IK_SHL : (op == OP_SHR) ? IK_SHR : IK_ASR;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        is_iter = 1'b1;
        kind    = IK_MUL;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    fo_d       = fo_q;
    iter_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_iter) begin
            iter_start = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            d_d     = alu_res;
            fo_d    = pack_flags(alu_c, alu_res == '0, alu_res[WIDTH-1], alu_v, alu_ill);
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (iter_last) begin
          d_d     = iter_res;
          fo_d    = pack_flags(iter_c, iter_res == '0, iter_res[WIDTH-1], 1'b0, 1'b0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      fo_q    <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      fo_q    <= fo_d;
    end
  end

  assign iter_step = (state_q == ST_BUSY);

  alu_seq_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (iter_start),
    .step_i  (iter_step),
    .kind_i  (kind),
    .a_i     (a),
    .b_i     (b),
    .res_o   (iter_res),
    .c_o     (iter_c),
    .last_o  (iter_last)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign d         = d_q;
  assign fo        = fo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8); multiply expectations follow ALU_MUL_EN.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ci = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] d;
  logic [7:0] fo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .fo        (fo)
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] d;
    logic [7:0] fo;
    int         lat;
  } vec_t;

  function automatic vec_t mk(string nm, logic [3:0] o, logic [7:0] xa, logic [7:0] xb,
                              logic xci, logic [7:0] xd, logic [7:0] xfo, int xl);
    vec_t v;
    v.name = nm; v.op = o; v.a = xa; v.b = xb; v.ci = xci;
    v.d = xd; v.fo = xfo; v.lat = xl;
    return v;
  endfunction

  // Presents one operation and counts cycles until out_valid (bounded).
  task automatic issue(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                       input logic t_ci, output int lat);
    @(negedge clk);
    op = t_op; a = t_a; b = t_b; ci = t_ci;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_d got=%h exp=00", d); end
    n_checks++; if (fo !== 8'h00) begin n_fail++; $display("FAIL reset_fo got=%h exp=00", fo); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    $display("reset: out_valid=%b d=%h fo=%h in_ready=%b", out_valid, d, fo, in_ready);
  endtask

  task automatic test_single_cycle();
    vec_t v[$];
    int   lat;
    v.push_back(mk("add_carry", OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h03, 1));
    v.push_back(mk("add_plain", OP_ADD, 8'h12, 8'h34, 1'b1, 8'h46, 8'h00, 1));
    v.push_back(mk("adc_ovf",   OP_ADC, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h0C, 1));
    v.push_back(mk("sub_ovf",   OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h08, 1));
    v.push_back(mk("sbb_borrow",OP_SBB, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h05, 1));
    v.push_back(mk("sub_zero",  OP_SUB, 8'h05, 8'h05, 1'b1, 8'h00, 8'h02, 1));
    v.push_back(mk("and",       OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1));
    v.push_back(mk("or",        OP_OR,  8'h80, 8'h01, 1'b0, 8'h81, 8'h04, 1));
    v.push_back(mk("xor_zero",  OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h02, 1));
    v.push_back(mk("not",       OP_NOT, 8'h0F, 8'h55, 1'b0, 8'hF0, 8'h04, 1));
    v.push_back(mk("illegal13", 4'd13,  8'h12, 8'h34, 1'b0, 8'h00, 8'h12, 1));
    v.push_back(mk("illegal15", 4'd15,  8'hFF, 8'hFF, 1'b1, 8'h00, 8'h12, 1));
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].ci, lat);
      $display("%s: op=%0d a=%h b=%h ci=%b -> d=%h fo=%h lat=%0d", v[i].name, v[i].op, v[i].a, v[i].b, v[i].ci, d, fo, lat);
      n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", v[i].name, lat, v[i].lat); end
      n_checks++; if (d !== v[i].d) begin n_fail++; $display("FAIL %s_d got=%h exp=%h", v[i].name, d, v[i].d); end
      n_checks++; if (fo !== v[i].fo) begin n_fail++; $display("FAIL %s_fo got=%h exp=%h", v[i].name, fo, v[i].fo); end
      consume();
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    int   lat;
    v.push_back(mk("shl3",     OP_SHL, 8'h81, 8'd3,   1'b0, 8'h08, 8'h00, 4));
    v.push_back(mk("asr9",     OP_ASR, 8'h80, 8'd9,   1'b0, 8'hFF, 8'h05, 9));
    v.push_back(mk("shr1",     OP_SHR, 8'h81, 8'd1,   1'b0, 8'h40, 8'h01, 2));
    v.push_back(mk("shl0",     OP_SHL, 8'h81, 8'd0,   1'b0, 8'h81, 8'h04, 1));
    v.push_back(mk("shr200",   OP_SHR, 8'hFF, 8'd200, 1'b0, 8'h00, 8'h03, 9));
    v.push_back(mk("shl8",     OP_SHL, 8'h01, 8'd8,   1'b0, 8'h00, 8'h03, 9));
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].ci, lat);
      $display("%s: op=%0d a=%h b=%h -> d=%h fo=%h lat=%0d", v[i].name, v[i].op, v[i].a, v[i].b, d, fo, lat);
      n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", v[i].name, lat, v[i].lat); end
      n_checks++; if (d !== v[i].d) begin n_fail++; $display("FAIL %s_d got=%h exp=%h", v[i].name, d, v[i].d); end
      n_checks++; if (fo !== v[i].fo) begin n_fail++; $display("FAIL %s_fo got=%h exp=%h", v[i].name, fo, v[i].fo); end
      consume();
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    int   lat;
`ifdef ALU_MUL_EN
    v.push_back(mk("mul_10x10", OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 8'h03, 9));
    v.push_back(mk("mul_0dx0b", OP_MUL, 8'h0D, 8'h0B, 1'b0, 8'h8F, 8'h04, 9));
    v.push_back(mk("mul_ffxff", OP_MUL, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'h01, 9));
`else
    v.push_back(mk("mul_off",   OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 8'h12, 1));
    v.push_back(mk("mul_off2",  OP_MUL, 8'h0D, 8'h0B, 1'b0, 8'h00, 8'h12, 1));
`endif
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, v[i].ci, lat);
      $display("%s: op=%0d a=%h b=%h -> d=%h fo=%h lat=%0d", v[i].name, v[i].op, v[i].a, v[i].b, d, fo, lat);
      n_checks++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", v[i].name, lat, v[i].lat); end
      n_checks++; if (d !== v[i].d) begin n_fail++; $display("FAIL %s_d got=%h exp=%h", v[i].name, d, v[i].d); end
      n_checks++; if (fo !== v[i].fo) begin n_fail++; $display("FAIL %s_fo got=%h exp=%h", v[i].name, fo, v[i].fo); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(OP_XOR, 8'h0F, 8'hF0, 1'b0, lat);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL bp_first_d got=%h exp=ff", d); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      op = OP_ADD; a = 8'h01; b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", k, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
      n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL bp_d_stable cyc=%0d got=%h exp=ff", k, d); end
      n_checks++; if (fo !== 8'h04) begin n_fail++; $display("FAIL bp_fo_stable cyc=%0d got=%h exp=04", k, fo); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept got=%b exp=0", out_valid); end
    $display("backpressure: held 5 cycles, released, d=%h fo=%h", d, fo);
  endtask

  task automatic test_reset_midop();
    int lat;
    @(negedge clk);
    op = OP_SHL; a = 8'h81; b = 8'd7; ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midop_busy got=%b exp=0", in_ready); end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midop_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL midop_d got=%h exp=00", d); end
    n_checks++; if (fo !== 8'h00) begin n_fail++; $display("FAIL midop_fo got=%h exp=00", fo); end
    @(negedge clk);
    rst = 1'b1;
    issue(OP_ADD, 8'h12, 8'h34, 1'b0, lat);
    $display("after_midop_reset: ADD 12+34 -> d=%h fo=%h lat=%0d", d, fo, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL midop_next_latency got=%0d exp=1", lat); end
    n_checks++; if (d !== 8'h46) begin n_fail++; $display("FAIL midop_next_d got=%h exp=46", d); end
    n_checks++; if (fo !== 8'h00) begin n_fail++; $display("FAIL midop_next_fo got=%h exp=00", fo); end
    consume();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
